// File: rtl/param_uop_sequencer_pkg.sv
// param_uop_pkg: shared encodings and sizing for the bit-serial uop sequencer.
//   - inst_type_e / br_cond_e: decoded instruction type and branch condition
//   - state_e: sequencer FSM states
//   - nibble/uop sizing constants and per-type uop counts
//   - decode_type(): maps reserved type codes onto ALU
//   - last_uop_idx(): index of the final uop for a given type
package param_uop_pkg;

   localparam int unsigned P_NBITS   = 4;
   localparam int unsigned C_N_OFF   = 32 / P_NBITS;
   localparam int unsigned C_OFFBITS = 3;
   localparam int unsigned C_UOPBITS = 2;

   localparam int unsigned C_UOPS_ALU  = 1;
   localparam int unsigned C_UOPS_BR   = 2;
   localparam int unsigned C_UOPS_JAL  = 2;
   localparam int unsigned C_UOPS_JALR = 2;

   typedef enum logic [2:0] {
      INST_ALU  = 3'd0,
      INST_BR   = 3'd1,
      INST_JAL  = 3'd2,
      INST_JALR = 3'd3
   } inst_type_e;

   typedef enum logic [1:0] {
      BR_BEQ = 2'd0,
      BR_BNE = 2'd1,
      BR_BLT = 2'd2,
      BR_BGE = 2'd3
   } br_cond_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_e;

   function automatic inst_type_e decode_type(input logic [2:0] raw);
      inst_type_e t;
      case (raw)
         3'd1:    t = INST_BR;
         3'd2:    t = INST_JAL;
         3'd3:    t = INST_JALR;
         default: t = INST_ALU;
      endcase
      return t;
   endfunction

   function automatic logic [C_UOPBITS-1:0] last_uop_idx(input inst_type_e t);
      int unsigned n;
      case (t)
         INST_BR:   n = C_UOPS_BR;
         INST_JAL:  n = C_UOPS_JAL;
         INST_JALR: n = C_UOPS_JALR;
         default:   n = C_UOPS_ALU;
      endcase
      return C_UOPBITS'(n - 1);
   endfunction

endpackage

// File: rtl/param_uop_sequencer_if.sv
// param_uop_sequencer_if: decode-to-X instruction handshake.
//   inst_val_Dhl   decoded instruction valid        (master -> slave)
//   inst_rdy_Dhl   sequencer can accept this cycle  (slave -> master)
//   inst_type_Dhl  instruction type, 3 bits         (master -> slave)
//   br_cond_Dhl    branch condition, 2 bits         (master -> slave)
interface param_uop_sequencer_if;

   logic       inst_val_Dhl;
   logic       inst_rdy_Dhl;
   logic [2:0] inst_type_Dhl;
   logic [1:0] br_cond_Dhl;

   modport master (
      output inst_val_Dhl,
      output inst_type_Dhl,
      output br_cond_Dhl,
      input  inst_rdy_Dhl
   );

   modport slave (
      input  inst_val_Dhl,
      input  inst_type_Dhl,
      input  br_cond_Dhl,
      output inst_rdy_Dhl
   );

endinterface

// File: rtl/param_uop_sequencer_counter.sv
// param_UopCounter: nibble index / uop index counter pair.
//   clk, reset        clock, synchronous active-low reset
//   clear             restart at uop 0, nibble 0 (priority over en)
//   en                advance one nibble
//   last_uop_idx      index of the final uop of the current instruction
//   nib_idx, uop_idx  current position
//   nib_final         on the last nibble of a uop
//   uop_final         on the final uop of the instruction
module param_UopCounter
   import param_uop_pkg::*;
#(
   parameter int unsigned C_OFFBITS = 3,
   parameter int unsigned C_UOPBITS = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 en,
   input  logic [C_UOPBITS-1:0] last_uop_idx,
   output logic [C_OFFBITS-1:0] nib_idx,
   output logic [C_UOPBITS-1:0] uop_idx,
   output logic                 nib_final,
   output logic                 uop_final
);

   assign nib_final = (nib_idx == C_OFFBITS'(C_N_OFF - 1));
   assign uop_final = (uop_idx == last_uop_idx);

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         nib_idx <= '0;
         uop_idx <= '0;
      end else if (en) begin
         nib_idx <= nib_final ? '0 : nib_idx + 1'b1;
         // wrapping after the final uop leaves the pair at 0 for the next instruction
         if (nib_final)
            uop_idx <= uop_final ? '0 : uop_idx + 1'b1;
      end
   end

endmodule

// File: rtl/param_uop_sequencer.sv
// param_uop_sequencer: X-stage bit-serial micro-op sequencer.
// Accepts one decoded instruction per handshake and steps it through its
// uops, one nibble per cycle, driving the serial PC / branch controls.
//   clk, reset              clock, synchronous active-low reset
//   inst_if (slave)         instruction handshake from decode
//   stall_Xhl               freeze sequencing this cycle
//   alu_eq_nib_Xhl          current ALU nibble operands equal
//   alu_lt_Xhl              signed less-than, valid on final compare nibble
//   last_uop_Xhl            final nibble of final uop (PC updates)
//   pc_mux_sel_Xhl          redirect PC to assembled target
//   b_use_imm_reg_Xhl       target comes from the address register
//   pc_plus4_mux_sel_Xhl    serial PC interface emits PC+4
//   a_mux_sel_Xhl           ALU A operand is the serial PC
//   addr_reg_en_Xhl         load ALU nibble into the address register
//   shift_dir_sel_Xhl       address demux direction (0 = LSB-first)
//   nib_idx_Xhl             current nibble index
module param_uop_sequencer
   import param_uop_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   param_uop_sequencer_if.slave   inst_if,
   input  logic                   stall_Xhl,
   input  logic                   alu_eq_nib_Xhl,
   input  logic                   alu_lt_Xhl,
   output logic                   last_uop_Xhl,
   output logic                   pc_mux_sel_Xhl,
   output logic                   b_use_imm_reg_Xhl,
   output logic                   pc_plus4_mux_sel_Xhl,
   output logic                   a_mux_sel_Xhl,
   output logic                   addr_reg_en_Xhl,
   output logic                   shift_dir_sel_Xhl,
   output logic [C_OFFBITS-1:0]   nib_idx_Xhl
);

   state_e                 state_q;
   inst_type_e             type_q;
   br_cond_e               cond_q;
   logic [C_UOPBITS-1:0]   last_idx_q;
   logic                   eq_acc_q;

   logic [C_OFFBITS-1:0]   nib_idx;
   logic [C_UOPBITS-1:0]   uop_idx;
   logic                   nib_final;
   logic                   uop_final;

   logic                   exec_live;
   logic                   step;
   logic                   last_int;
   logic                   accept;
   logic                   eq_now;
   logic                   taken;
   inst_type_e             new_type;

   // outputs are forced low while reset is asserted, even mid-instruction
   assign exec_live = (state_q == S_EXEC) && reset;
   assign step      = exec_live && !stall_Xhl;
   assign last_int  = step && nib_final && uop_final;

   assign inst_if.inst_rdy_Dhl = reset && ((state_q == S_IDLE) || last_int);
   assign accept   = inst_if.inst_val_Dhl && inst_if.inst_rdy_Dhl;
   assign new_type = decode_type(inst_if.inst_type_Dhl);

   // the accumulator restarts at nibble 0, so its stored value is ignored there
   assign eq_now = alu_eq_nib_Xhl && ((nib_idx == '0) || eq_acc_q);

   param_UopCounter #(
      .C_OFFBITS (C_OFFBITS),
      .C_UOPBITS (C_UOPBITS)
   ) u_counter (
      .clk          (clk),
      .reset        (reset),
      .clear        (accept),
      .en           (step),
      .last_uop_idx (last_idx_q),
      .nib_idx      (nib_idx),
      .uop_idx      (uop_idx),
      .nib_final    (nib_final),
      .uop_final    (uop_final)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         type_q     <= INST_ALU;
         cond_q     <= BR_BEQ;
         last_idx_q <= '0;
         eq_acc_q   <= 1'b1;
      end else begin
         if (step && (type_q == INST_BR) && (uop_idx == C_UOPBITS'(1)))
            eq_acc_q <= eq_now;
         if (accept) begin
            state_q    <= S_EXEC;
            type_q     <= new_type;
            cond_q     <= br_cond_e'(inst_if.br_cond_Dhl);
            last_idx_q <= last_uop_idx(new_type);
            eq_acc_q   <= 1'b1;
         end else if (last_int) begin
            state_q <= S_IDLE;
         end
      end
   end

   always_comb begin
      taken = 1'b0;
      case (cond_q)
         BR_BEQ:  taken = eq_now;
         BR_BNE:  taken = !eq_now;
         BR_BLT:  taken = alu_lt_Xhl;
         BR_BGE:  taken = !alu_lt_Xhl;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      a_mux_sel_Xhl        = 1'b0;
      addr_reg_en_Xhl      = 1'b0;
      pc_plus4_mux_sel_Xhl = 1'b0;
      b_use_imm_reg_Xhl    = 1'b0;
      pc_mux_sel_Xhl       = 1'b0;
      shift_dir_sel_Xhl    = 1'b0;
      last_uop_Xhl         = last_int;
      nib_idx_Xhl          = exec_live ? nib_idx : '0;
      if (exec_live) begin
         b_use_imm_reg_Xhl = (type_q != INST_ALU);
         case (type_q)
            INST_BR: begin
               a_mux_sel_Xhl   = (uop_idx == '0);
               addr_reg_en_Xhl = (uop_idx == '0);
               pc_mux_sel_Xhl  = last_int && taken;
            end
            INST_JAL: begin
               a_mux_sel_Xhl        = 1'b1;
               addr_reg_en_Xhl      = (uop_idx == '0);
               pc_plus4_mux_sel_Xhl = (uop_idx != '0);
               pc_mux_sel_Xhl       = last_int;
            end
            INST_JALR: begin
               a_mux_sel_Xhl        = (uop_idx != '0);
               addr_reg_en_Xhl      = (uop_idx == '0);
               pc_plus4_mux_sel_Xhl = (uop_idx != '0);
               pc_mux_sel_Xhl       = last_int;
            end
            default: ;
         endcase
         if (stall_Xhl) begin
            a_mux_sel_Xhl   = 1'b0;
            addr_reg_en_Xhl = 1'b0;
         end
      end
   end

endmodule
